// File: rtl/score_display_ctrl_if.sv
// Game-event and display bus between the flappybrick game FSM, the score
// controller and the board seven-segment pins.
interface score_display_ctrl_if;
  logic       pass;
  logic       lose;
  logic       restart;
  logic [7:0] seg_select;
  logic [6:0] seven_seg;
  logic       new_record;
  logic [1:0] state;

  modport master (
    output pass, lose, restart,
    input  seg_select, seven_seg, new_record, state
  );

  modport slave (
    input  pass, lose, restart,
    output seg_select, seven_seg, new_record, state
  );
endinterface

// File: rtl/score_display_ctrl.sv
// BCD score/high-score keeper with a multiplexed active-low 4-digit display
// that alternates between score and high score after a loss.
module score_display_ctrl #(
  parameter int SCAN_DIV   = 256,
  parameter int ALT_CYCLES = 100_000_000
) (
  input logic clk,
  input logic rst,
  score_display_ctrl_if.slave bus
);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int ALT_W  = $clog2(ALT_CYCLES);

  typedef enum logic [1:0] {
    PLAY       = 2'b00,
    SHOW_SCORE = 2'b01,
    SHOW_HIGH  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [ALT_W-1:0]   view_cnt;
  logic               view_done;
  logic [15:0]        score, high;
  logic               new_record_q;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic [15:0]        shown;
  logic [3:0]         digit;
  logic               blank;
  logic [6:0]         seg_next;
  logic [7:0]         seg_select_q;
  logic [6:0]         seven_seg_q;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  assign view_done = (view_cnt == ALT_W'(ALT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PLAY;
    else     state_q <= state_d;
  end

  // restart overrides everything; lose is only meaningful while playing
  always_comb begin
    state_d = state_q;
    case (state_q)
      PLAY:       if (bus.lose) state_d = SHOW_SCORE;
      SHOW_SCORE: if (view_done) state_d = SHOW_HIGH;
      SHOW_HIGH:  if (view_done) state_d = SHOW_SCORE;
      default:    state_d = PLAY;
    endcase
    if (bus.restart) state_d = PLAY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    view_cnt <= '0;
    else if (state_d != state_q) view_cnt <= '0;
    else if (state_q != PLAY)    view_cnt <= view_cnt + 1'b1;
    else                         view_cnt <= '0;
  end

  // BCD digits compare correctly as plain binary, so score > high is direct
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score        <= '0;
      high         <= '0;
      new_record_q <= 1'b0;
    end else if (bus.restart) begin
      score        <= '0;
      new_record_q <= 1'b0;
    end else if (state_q == PLAY) begin
      if (bus.lose) begin
        if (score > high) begin
          high         <= score;
          new_record_q <= 1'b1;
        end
      end else if (bus.pass) begin
        score <= bcd_inc(score);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    shown = (state_q == SHOW_HIGH) ? high : score;
    digit = shown[3:0];
    blank = 1'b0;
    case (idx)
      2'd0: begin digit = shown[3:0];   blank = 1'b0;                  end
      2'd1: begin digit = shown[7:4];   blank = (shown[15:4]  == '0); end
      2'd2: begin digit = shown[11:8];  blank = (shown[15:8]  == '0); end
      default: begin digit = shown[15:12]; blank = (shown[15:12] == '0); end
    endcase
    seg_next = blank ? 7'h7F : decode(digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_select_q <= 8'hFF;
      seven_seg_q  <= 7'h7F;
    end else begin
      seg_select_q <= {4'hF, ~(4'b0001 << idx)};
      seven_seg_q  <= seg_next;
    end
  end

  assign bus.seg_select = seg_select_q;
  assign bus.seven_seg  = seven_seg_q;
  assign bus.new_record = new_record_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl using small scan/alternation periods.
module tb_score_display_ctrl;
  localparam int SCAN_DIV   = 4;
  localparam int ALT_CYCLES = 64;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  score_display_ctrl_if dif();

  score_display_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .ALT_CYCLES(ALT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
    end
  endtask

  // drives one cycle of pulses starting at a negedge; returns on the next negedge
  task automatic applyStimulus(input logic p, input logic l, input logic r);
    dif.pass    = p;
    dif.lose    = l;
    dif.restart = r;
    @(negedge clk);
    dif.pass    = 1'b0;
    dif.lose    = 1'b0;
    dif.restart = 1'b0;
  endtask

  task automatic readDigit(input int i, output logic [6:0] seg, output bit found);
    logic [7:0] want;
    want  = ~(8'h01 << i);
    found = 1'b0;
    seg   = 7'h7F;
    for (int k = 0; k < 4 * SCAN_DIV + 2; k++) begin
      @(negedge clk);
      if (dif.seg_select == want) begin
        found = 1'b1;
        seg   = dif.seven_seg;
        break;
      end
    end
  endtask

  task automatic checkDigit(input string tag, input int i, input logic [6:0] expected);
    logic [6:0] seg;
    bit         found;
    readDigit(i, seg, found);
    if (!found) checkOutput({tag, "_select"}, 16'(dif.seg_select), 16'(~(8'h01 << i)));
    else        checkOutput(tag, 16'(seg), 16'(expected));
  endtask

  task automatic waitState(input string tag, input logic [1:0] target, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (dif.state == target) break;
      @(negedge clk);
    end
    checkOutput(tag, 16'(dif.state), 16'(target));
  endtask

  initial begin
    int t0;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    dif.pass    = 1'b0;
    dif.lose    = 1'b0;
    dif.restart = 1'b0;
    rst         = 1'b1;
    #2;
    checkOutput("rst_sel", 16'(dif.seg_select), 16'h00FF);
    checkOutput("rst_seg", 16'(dif.seven_seg), 16'h007F);
    checkOutput("rst_state", 16'(dif.state), 16'h0000);
    checkOutput("rst_newrec", 16'(dif.new_record), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      logic [7:0] sel_exp;
      int         d;
      @(negedge clk);
      d       = (k / SCAN_DIV) % 4;
      sel_exp = ~(8'h01 << d);
      checkOutput("scan_sel", 16'(dif.seg_select), 16'(sel_exp));
      checkOutput("scan_seg", 16'(dif.seven_seg), (d == 0) ? 16'h0040 : 16'h007F);
    end

    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkDigit("s12_d0", 0, 7'h24);
    checkDigit("s12_d1", 1, 7'h79);
    checkDigit("s12_d2", 2, 7'h7F);
    checkDigit("s12_d3", 3, 7'h7F);

    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9999; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkDigit("s9999_d0", 0, 7'h10);
    checkDigit("s9999_d1", 1, 7'h10);
    checkDigit("s9999_d2", 2, 7'h10);
    checkDigit("s9999_d3", 3, 7'h10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkDigit("wrap_d0", 0, 7'h40);
    checkDigit("wrap_d1", 1, 7'h7F);
    checkDigit("wrap_d2", 2, 7'h7F);
    checkDigit("wrap_d3", 3, 7'h7F);
    checkOutput("wrap_state", 16'(dif.state), 16'h0000);

    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    t0 = cyc;
    checkOutput("lose_state", 16'(dif.state), 16'h0001);
    checkOutput("lose_newrec", 16'(dif.new_record), 16'h0001);
    waitState("alt_to_high", 2'b10, 4 * ALT_CYCLES);
    checkOutput("alt1_period", 16'(cyc - t0), 16'(ALT_CYCLES));
    t0 = cyc;
    checkDigit("high_d0", 0, 7'h24);
    checkDigit("high_d1", 1, 7'h79);
    checkDigit("high_d2", 2, 7'h7F);
    checkDigit("high_d3", 3, 7'h7F);
    waitState("alt_to_score", 2'b01, 4 * ALT_CYCLES);
    checkOutput("alt2_period", 16'(cyc - t0), 16'(ALT_CYCLES));

    waitState("back_high", 2'b10, 4 * ALT_CYCLES);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rsl_state", 16'(dif.state), 16'h0000);
    checkOutput("rsl_newrec", 16'(dif.new_record), 16'h0000);
    checkDigit("rsl_d0", 0, 7'h40);
    checkDigit("rsl_d1", 1, 7'h7F);

    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("g2_state", 16'(dif.state), 16'h0001);
    checkOutput("g2_newrec", 16'(dif.new_record), 16'h0000);
    checkDigit("g2_score_d0", 0, 7'h12);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ign_state", 16'(dif.state), 16'h0001);
    checkOutput("ign_newrec", 16'(dif.new_record), 16'h0000);
    checkDigit("ign_d0", 0, 7'h12);
    waitState("g2_to_high", 2'b10, 4 * ALT_CYCLES);
    checkDigit("g2_high_d0", 0, 7'h24);
    checkDigit("g2_high_d1", 1, 7'h79);

    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_sel", 16'(dif.seg_select), 16'h00FF);
    checkOutput("mid_rst_seg", 16'(dif.seven_seg), 16'h007F);
    checkOutput("mid_rst_state", 16'(dif.state), 16'h0000);
    checkOutput("mid_rst_newrec", 16'(dif.new_record), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_newrec", 16'(dif.new_record), 16'h0001);
    checkDigit("post_rst_d0", 0, 7'h79);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
